// File: rtl/uart_param_transceiver_if.sv
// uart_param_transceiver_if: host-side transmit handshake and RX FIFO read port
interface uart_param_transceiver_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) ();
   logic [DATA_BITS-1:0]        TX_data;
   logic                        TX_valid;
   logic                        TX_ready;
   logic [DATA_BITS-1:0]        RX_data;
   logic                        RX_valid;
   logic                        RX_read;
   logic                        RX_parity_error;
   logic [$clog2(FIFO_DEPTH):0] RX_count;
   logic                        RX_frame_error;
   logic                        RX_overflow;
   modport slave (
      input  TX_data, TX_valid, RX_read,
      output TX_ready, RX_data, RX_valid, RX_parity_error, RX_count, RX_frame_error, RX_overflow
   );
   modport master (
      output TX_data, TX_valid, RX_read,
      input  TX_ready, RX_data, RX_valid, RX_parity_error, RX_count, RX_frame_error, RX_overflow
   );
endinterface

// File: rtl/uart_param_transceiver.sv
// uart_param_transceiver: parameterised UART transmitter and receiver with a first-word fall-through RX FIFO
module uart_param_transceiver #(
   parameter int CLK_HZ      = 100000000,
   parameter int BAUD        = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic Clock_100MHz,
   input  logic Reset_n,
   input  logic TXD,
   output logic RXD,
   uart_param_transceiver_if.slave host
);
   localparam int DIV = CLK_HZ / (BAUD * 16);
   localparam int DW  = $clog2(DIV + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic [DW-1:0] div_q;
   logic tick;
   state_t ts_q, ts_d, rs_q, rs_d;
   logic [3:0] tsc_q, tsc_d, rsc_q, rsc_d;
   logic [2:0] tb_q, tb_d, rb_q, rb_d;
   logic [DATA_BITS-1:0] tsh_q, tsh_d, rsh_q, rsh_d;
   logic tpar_q, tpar_d, tpend_q, tpend_d, rperr_q, rperr_d;
   logic s1_q, s2_q, s3_q, fe_q, fe_d, ov_q, wr, push, pop, full, tend, rsmp, rend;
   logic [DATA_BITS:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   assign tick = div_q == DW'(DIV - 1);
   assign tend = tick && tsc_q == 4'd15;
   assign rsmp = tick && rsc_q == 4'd7;
   assign rend = tick && rsc_q == 4'd15;
   assign host.TX_ready = ts_q == IDLE && !tpend_q;
   assign RXD = ts_q == START ? 1'b0 : ts_q == DATA ? tsh_q[0] : ts_q == PARITY ? tpar_q : 1'b1;
   always_comb begin
      ts_d = ts_q;
      tsc_d = tick ? tsc_q + 4'd1 : tsc_q;
      tb_d = tb_q;
      tsh_d = tsh_q;
      tpar_d = tpar_q;
      tpend_d = tpend_q;
      case (ts_q)
         IDLE: begin
            tsc_d = '0;
            if (host.TX_valid && host.TX_ready) begin
               tpend_d = 1'b1;
               tsh_d = host.TX_data;
               tpar_d = ^host.TX_data ^ (PARITY_MODE == 2);
            end else if (tpend_q && tick) begin
               tpend_d = 1'b0;
               ts_d = START;
            end
         end
         START: if (tend) begin
            ts_d = DATA;
            tb_d = '0;
         end
         DATA: if (tend) begin
            tsh_d = tsh_q >> 1;
            tb_d = tb_q + 3'd1;
            if (tb_q == 3'(DATA_BITS - 1)) begin
               ts_d = PARITY_MODE != 0 ? PARITY : STOP;
               tb_d = '0;
            end
         end
         PARITY: if (tend) ts_d = STOP;
         STOP: if (tend) begin
            tb_d = tb_q + 3'd1;
            if (tb_q == 3'(STOP_BITS - 1)) ts_d = IDLE;
         end
         default: ts_d = IDLE;
      endcase
   end
   // the line is sampled at tick 8 of every bit; IDLE holds the tick counter at zero so bit timing starts at the edge
   always_comb begin
      rs_d = rs_q;
      rsc_d = tick ? rsc_q + 4'd1 : rsc_q;
      rb_d = rb_q;
      rsh_d = rsh_q;
      rperr_d = rperr_q;
      wr = 1'b0;
      fe_d = 1'b0;
      case (rs_q)
         IDLE: begin
            rsc_d = '0;
            rperr_d = 1'b0;
            if (s3_q && !s2_q) rs_d = START;
         end
         START: if (rsmp && s2_q) rs_d = IDLE;
            else if (rend) begin
               rs_d = DATA;
               rb_d = '0;
            end
         DATA: begin
            if (rsmp) rsh_d = {s2_q, rsh_q[DATA_BITS-1:1]};
            if (rend) begin
               rb_d = rb_q + 3'd1;
               if (rb_q == 3'(DATA_BITS - 1)) rs_d = PARITY_MODE != 0 ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (rsmp) rperr_d = s2_q ^ (^rsh_q) ^ (PARITY_MODE == 2);
            if (rend) rs_d = STOP;
         end
         STOP: if (rsmp) begin
            rs_d = IDLE;
            wr = s2_q;
            fe_d = !s2_q;
         end
         default: rs_d = IDLE;
      endcase
   end
   assign full = cnt_q == CW'(FIFO_DEPTH);
   assign pop = host.RX_read && cnt_q != '0;
   assign push = wr && (!full || pop);
   assign host.RX_valid = cnt_q != '0;
   assign host.RX_data = host.RX_valid ? mem[rp_q][DATA_BITS-1:0] : '0;
   assign host.RX_parity_error = host.RX_valid && mem[rp_q][DATA_BITS];
   assign host.RX_count = cnt_q;
   assign host.RX_frame_error = fe_q;
   assign host.RX_overflow = ov_q;
   always_ff @(posedge Clock_100MHz)
      if (push) mem[wp_q] <= {rperr_q, rsh_q};
   // synchroniser resets low so a line already low at release never looks like a falling edge
   always_ff @(posedge Clock_100MHz or negedge Reset_n)
      if (!Reset_n) begin
         div_q <= '0;
         ts_q <= IDLE;
         tsc_q <= '0;
         tb_q <= '0;
         tsh_q <= '0;
         tpar_q <= 1'b0;
         tpend_q <= 1'b0;
         rs_q <= IDLE;
         rsc_q <= '0;
         rb_q <= '0;
         rsh_q <= '0;
         rperr_q <= 1'b0;
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         fe_q <= 1'b0;
         ov_q <= 1'b0;
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + 1'b1;
         ts_q <= ts_d;
         tsc_q <= tsc_d;
         tb_q <= tb_d;
         tsh_q <= tsh_d;
         tpar_q <= tpar_d;
         tpend_q <= tpend_d;
         rs_q <= rs_d;
         rsc_q <= rsc_d;
         rb_q <= rb_d;
         rsh_q <= rsh_d;
         rperr_q <= rperr_d;
         s1_q <= TXD;
         s2_q <= s1_q;
         s3_q <= s2_q;
         fe_q <= fe_d;
         ov_q <= wr && full && !pop;
         wp_q <= wp_q + AW'(push);
         rp_q <= rp_q + AW'(pop);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
endmodule

// File: tb/tb_uart_param_transceiver.sv
// tb_uart_param_transceiver: directed checks of TX framing, RX parity/framing/glitch, FIFO overflow and mid-frame reset
module tb_uart_param_transceiver;
   localparam int BIT = 160;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic txd_a = 1'b1, txd_b = 1'b1;
   logic rxd_a, rxd_b;
   int n_chk = 0, n_fail = 0, fe_cnt = 0, ov_cnt = 0;
   always #5 clk = ~clk;
   uart_param_transceiver_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
   uart_param_transceiver_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) ifb ();
   uart_param_transceiver #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_a (.Clock_100MHz(clk), .Reset_n(rst_n), .TXD(txd_a), .RXD(rxd_a), .host(ifa));
   uart_param_transceiver #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(16))
      dut_b (.Clock_100MHz(clk), .Reset_n(rst_n), .TXD(txd_b), .RXD(rxd_b), .host(ifb));
   always @(negedge clk) begin
      if (ifa.RX_frame_error) fe_cnt++;
      if (ifa.RX_overflow) ov_cnt++;
   end
   task automatic drive(input bit sel, input logic v);
      if (sel) txd_b = v;
      else txd_a = v;
      repeat (BIT) @(negedge clk);
   endtask
   task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic par, input logic stp);
      drive(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive(sel, d[i]);
      if (has_par) drive(sel, par);
      drive(sel, stp);
      drive(sel, 1'b1);
   endtask
   task automatic pop(input bit sel);
      @(negedge clk);
      if (sel) ifb.RX_read = 1'b1;
      else ifa.RX_read = 1'b1;
      @(negedge clk);
      ifa.RX_read = 1'b0;
      ifb.RX_read = 1'b0;
   endtask
   task automatic test_reset();
      repeat (5) @(negedge clk);
      n_chk += 9;
      if (rxd_a !== 1'b1) begin n_fail++; $display("FAIL rst_rxd_a: got %b want 1", rxd_a); end
      if (rxd_b !== 1'b1) begin n_fail++; $display("FAIL rst_rxd_b: got %b want 1", rxd_b); end
      if (ifa.TX_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 1", ifa.TX_ready); end
      if (ifa.RX_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", ifa.RX_valid); end
      if (ifa.RX_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", ifa.RX_data); end
      if (ifa.RX_parity_error !== 1'b0) begin n_fail++; $display("FAIL rst_perr: got %b want 0", ifa.RX_parity_error); end
      if (ifa.RX_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", ifa.RX_count); end
      if (ifa.RX_frame_error !== 1'b0) begin n_fail++; $display("FAIL rst_fe: got %b want 0", ifa.RX_frame_error); end
      if (ifa.RX_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %b want 0", ifa.RX_overflow); end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
   endtask
   task automatic test_tx(input logic [7:0] d, input bit poke);
      logic [9:0] exp;
      int k, bad;
      exp = {1'b1, d, 1'b0};
      @(negedge clk);
      ifa.TX_data = d;
      ifa.TX_valid = 1'b1;
      @(negedge clk);
      ifa.TX_valid = 1'b0;
      n_chk++;
      if (ifa.TX_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_drop: got %b want 0", ifa.TX_ready); end
      k = 0;
      while (rxd_a !== 1'b0 && k < 100) begin @(negedge clk); k++; end
      n_chk++;
      if (k >= 100) begin n_fail++; $display("FAIL tx_start_timeout: waited %0d cycles want < 100", k); end
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int i = 0; i < BIT; i++) begin
            if (rxd_a !== exp[b]) bad++;
            if (poke && b == 5 && i == 0) begin ifa.TX_valid = 1'b1; ifa.TX_data = ~d; end
            if (b == 9 && i == BIT - 1) begin
               n_chk++;
               if (ifa.TX_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_busy: got %b want 0", ifa.TX_ready); end
               ifa.TX_valid = 1'b0;
            end
            @(negedge clk);
         end
         n_chk++;
         if (bad != 0) begin n_fail++; $display("FAIL tx_bit%0d: %0d samples differ from required %b", b, bad, exp[b]); end
      end
      n_chk++;
      if (ifa.TX_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_back: got %b want 1", ifa.TX_ready); end
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (rxd_a !== 1'b1) bad++;
         @(negedge clk);
      end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL tx_idle_after: %0d low samples want 0", bad); end
   endtask
   task automatic test_parity();
      send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      n_chk += 3;
      if (ifb.RX_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid: got %b want 1", ifb.RX_valid); end
      if (ifb.RX_data !== 8'h07) begin n_fail++; $display("FAIL par_ok_data: got %h want 07", ifb.RX_data); end
      if (ifb.RX_parity_error !== 1'b0) begin n_fail++; $display("FAIL par_ok_flag: got %b want 0", ifb.RX_parity_error); end
      pop(1'b1);
      send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      n_chk += 3;
      if (ifb.RX_data !== 8'h07) begin n_fail++; $display("FAIL par_bad_data: got %h want 07", ifb.RX_data); end
      if (ifb.RX_parity_error !== 1'b1) begin n_fail++; $display("FAIL par_bad_flag: got %b want 1", ifb.RX_parity_error); end
      if (ifb.RX_count !== 5'd1) begin n_fail++; $display("FAIL par_bad_count: got %0d want 1", ifb.RX_count); end
      pop(1'b1);
      n_chk++;
      if (ifb.RX_count !== 5'd0) begin n_fail++; $display("FAIL par_pop_count: got %0d want 0", ifb.RX_count); end
   endtask
   task automatic test_frame_error();
      int f0;
      f0 = fe_cnt;
      send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      n_chk += 3;
      if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL fe_pulses: got %0d want 1", fe_cnt - f0); end
      if (ifa.RX_count !== 3'd0) begin n_fail++; $display("FAIL fe_count: got %0d want 0", ifa.RX_count); end
      if (ifa.RX_valid !== 1'b0) begin n_fail++; $display("FAIL fe_valid: got %b want 0", ifa.RX_valid); end
   endtask
   task automatic test_overflow();
      int o0;
      o0 = ov_cnt;
      for (int c = 1; c <= 4; c++) send(1'b0, 8'(c), 1'b0, 1'b0, 1'b1);
      n_chk += 2;
      if (ov_cnt != o0) begin n_fail++; $display("FAIL ov_early: got %0d pulses want 0", ov_cnt - o0); end
      if (ifa.RX_count !== 3'd4) begin n_fail++; $display("FAIL ov_full_count: got %0d want 4", ifa.RX_count); end
      send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
      n_chk += 2;
      if (ov_cnt - o0 != 1) begin n_fail++; $display("FAIL ov_pulse: got %0d pulses want 1", ov_cnt - o0); end
      if (ifa.RX_count !== 3'd4) begin n_fail++; $display("FAIL ov_count: got %0d want 4", ifa.RX_count); end
      for (int c = 1; c <= 4; c++) begin
         n_chk++;
         if (ifa.RX_data !== 8'(c)) begin n_fail++; $display("FAIL ov_read%0d: got %h want %h", c, ifa.RX_data, 8'(c)); end
         pop(1'b0);
      end
      n_chk++;
      if (ifa.RX_valid !== 1'b0) begin n_fail++; $display("FAIL ov_drained: got %b want 0", ifa.RX_valid); end
      pop(1'b0);
      n_chk += 2;
      if (ifa.RX_count !== 3'd0) begin n_fail++; $display("FAIL empty_read_count: got %0d want 0", ifa.RX_count); end
      if (ifa.RX_valid !== 1'b0) begin n_fail++; $display("FAIL empty_read_valid: got %b want 0", ifa.RX_valid); end
   endtask
   task automatic test_glitch();
      int f0;
      f0 = fe_cnt;
      @(negedge clk);
      txd_a = 1'b0;
      repeat (40) @(negedge clk);
      txd_a = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      n_chk += 3;
      if (ifa.RX_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", ifa.RX_valid); end
      if (ifa.RX_count !== 3'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", ifa.RX_count); end
      if (fe_cnt != f0) begin n_fail++; $display("FAIL glitch_fe: got %0d pulses want 0", fe_cnt - f0); end
      send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      n_chk += 2;
      if (ifa.RX_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data: got %h want 3c", ifa.RX_data); end
      if (ifa.RX_count !== 3'd1) begin n_fail++; $display("FAIL glitch_next_count: got %0d want 1", ifa.RX_count); end
      pop(1'b0);
   endtask
   task automatic test_reset_mid();
      int f0;
      f0 = fe_cnt;
      @(negedge clk);
      ifa.TX_data = 8'hA4;
      ifa.TX_valid = 1'b1;
      txd_a = 1'b0;
      @(negedge clk);
      ifa.TX_valid = 1'b0;
      repeat (239) @(negedge clk);
      n_chk += 2;
      if (rxd_a !== 1'b0) begin n_fail++; $display("FAIL mid_rxd_before: got %b want 0", rxd_a); end
      if (ifa.TX_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_before: got %b want 0", ifa.TX_ready); end
      #3 rst_n = 1'b0;
      #1;
      n_chk += 3;
      if (rxd_a !== 1'b1) begin n_fail++; $display("FAIL mid_rxd_reset: got %b want 1", rxd_a); end
      if (ifa.TX_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_reset: got %b want 1", ifa.TX_ready); end
      if (ifa.RX_count !== 3'd0) begin n_fail++; $display("FAIL mid_count_reset: got %0d want 0", ifa.RX_count); end
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      txd_a = 1'b1;
      repeat (400) @(negedge clk);
      n_chk += 2;
      if (ifa.RX_count !== 3'd0) begin n_fail++; $display("FAIL mid_release_count: got %0d want 0", ifa.RX_count); end
      if (fe_cnt != f0) begin n_fail++; $display("FAIL mid_release_fe: got %0d pulses want 0", fe_cnt - f0); end
      fork
         test_tx(8'hA5, 1'b0);
         send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      join
      n_chk += 3;
      if (ifa.RX_data !== 8'hA5) begin n_fail++; $display("FAIL mid_next_data: got %h want a5", ifa.RX_data); end
      if (ifa.RX_parity_error !== 1'b0) begin n_fail++; $display("FAIL mid_next_perr: got %b want 0", ifa.RX_parity_error); end
      if (ifa.RX_count !== 3'd1) begin n_fail++; $display("FAIL mid_next_count: got %0d want 1", ifa.RX_count); end
      pop(1'b0);
   endtask
   initial begin
      ifa.TX_data = '0;
      ifa.TX_valid = 1'b0;
      ifa.RX_read = 1'b0;
      ifb.TX_data = '0;
      ifb.TX_valid = 1'b0;
      ifb.RX_read = 1'b0;
      test_reset();
      test_tx(8'h41, 1'b1);
      test_parity();
      test_frame_error();
      test_overflow();
      test_glitch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
